// File: rtl/fetch_ram_rd_ctrl.sv
// fetch_ram_rd_ctrl: sequential fetch-RAM burst reader with 2-entry skid FIFO and valid/ready/last stream
module fetch_ram_rd_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 144
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rden_o,
    output logic [ADDR_W-1:0] rdaddr_o,
    input  logic [DATA_W-1:0] rddata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [ADDR_W:0] len_c, issue_left, out_left;
    logic [ADDR_W-1:0] next_addr, last_addr;
    logic [DATA_W-1:0] mem [2];
    logic [1:0] fifo_cnt;
    logic rden_q, done_q, wr_ptr, rd_ptr, pop, accept, finish;
    assign len_c    = (len_i > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len_i;
    assign valid_o  = fifo_cnt != 2'd0;
    assign data_o   = mem[rd_ptr];
    assign last_o   = valid_o && out_left == (ADDR_W+1)'(1);
    assign pop      = valid_o && ready_i;
    assign accept   = state == IDLE && start_i;
    assign finish   = pop && last_o;
    assign busy_o   = state != IDLE;
    assign done_o   = done_q;
    // Issue only if the word can land without overflowing the FIFO even if the consumer stalls from now on.
    assign rden_o   = state == RUN && issue_left != '0 &&
                      ({1'b0, fifo_cnt} + {2'b0, rden_q} - {2'b0, pop}) < 3'd2;
    assign rdaddr_o = rden_o ? next_addr : last_addr;
    always_comb begin
        state_nx = (state == IDLE && start_i && len_c != '0)                  ? RUN   :
                   (state == RUN && rden_o && issue_left == (ADDR_W+1)'(1)) ? DRAIN :
                   (state == DRAIN && finish)                                ? IDLE  : state;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            issue_left <= '0;
            out_left   <= '0;
            next_addr  <= '0;
            last_addr  <= '0;
            rden_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= '0;
            mem        <= '{default: '0};
        end else begin
            state    <= state_nx;
            rden_q   <= rden_o;
            done_q   <= (accept && len_c == '0) || (state == DRAIN && finish);
            fifo_cnt <= fifo_cnt + {1'b0, rden_q} - {1'b0, pop};
            if (accept) begin
                issue_left <= len_c;
                out_left   <= len_c;
                next_addr  <= base_addr_i;
            end else begin
                if (rden_o) begin
                    issue_left <= issue_left - 1'b1;
                    last_addr  <= next_addr;
                    next_addr  <= (next_addr == ADDR_W'(DEPTH - 1)) ? '0 : next_addr + 1'b1;
                end
                if (pop)
                    out_left <= out_left - 1'b1;
            end
            // SRAM data is valid the cycle after rden_o, so the in-flight flag is the write strobe.
            if (rden_q) begin
                mem[wr_ptr] <= rddata_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end
endmodule

// File: tb/tb_fetch_ram_rd_ctrl.sv
// tb_fetch_ram_rd_ctrl: randomized bench for fetch_ram_rd_ctrl against a RAM model and a
// reference stream computed from base/len arithmetic.
module tb_fetch_ram_rd_ctrl;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 144;

    logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, ready_i = 1'b1;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [ADDR_W:0]   len_i = '0;
    logic [DATA_W-1:0] rddata_i = '0;
    logic busy_o, done_o, rden_o, valid_o, last_o;
    logic [ADDR_W-1:0] rdaddr_o;
    logic [DATA_W-1:0] data_o;

    fetch_ram_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .rden_o(rden_o), .rdaddr_o(rdaddr_o), .rddata_i(rddata_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [DATA_W-1:0] ram [DEPTH];
    bit rand_ready = 1'b0;

    always @(posedge clk) if (rden_o) rddata_i <= ram[rdaddr_o];
    always @(posedge clk) begin
        #1;
        ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor: records handshakes/reads and models FIFO occupancy from observed traffic.
    logic [DATA_W-1:0] got_data [$];
    bit got_last [$];
    int rd_addrs [$];
    int dones, viol, stab, occ;
    bit prev_rden, stalled, busy_seen, mon_pop;
    logic [DATA_W-1:0] held_d;
    logic held_l;

    always @(negedge clk) begin
        if (rst_i) begin
            occ = 0; prev_rden = 0; stalled = 0;
        end else begin
            mon_pop = valid_o && ready_i;
            if (rden_o) begin
                rd_addrs.push_back(int'(rdaddr_o));
                if (occ + int'(prev_rden) - int'(mon_pop) >= 2) viol++;
            end
            if (valid_o !== (occ != 0) || occ > 2) viol++;
            if (stalled && (!valid_o || data_o !== held_d || last_o !== held_l)) stab++;
            if (mon_pop) begin
                got_data.push_back(data_o);
                got_last.push_back(last_o);
            end
            if (done_o) dones++;
            if (busy_o) busy_seen = 1;
            stalled = valid_o && !ready_i;
            held_d = data_o;
            held_l = last_o;
            occ = occ + int'(prev_rden) - int'(mon_pop);
            prev_rden = rden_o;
        end
    end

    task automatic clear_mon();
        got_data.delete(); got_last.delete(); rd_addrs.delete();
        dones = 0; viol = 0; stab = 0; busy_seen = 0;
    endtask

    task automatic kick(input int base, input int len);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = ADDR_W'(base); len_i = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run_burst(input int base, input int len, input int inj, output bit to);
        clear_mon();
        kick(base, len);
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == inj) begin
                start_i = 1'b1; base_addr_i = 8'd50; len_i = 9'd5;
            end else start_i = 1'b0;
            if (done_o) begin to = 1'b0; break; end
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, rden_o, valid_o, last_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy_o, done_o, rden_o, valid_o, last_o});
        end
        n_checks++;
        if (rdaddr_o !== '0 || data_o !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr %0h data %0h expected 0 0", rdaddr_o, data_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [4:0] exp_v;
        rand_ready = 1'b0;
        clear_mon();
        kick(0, 4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_v = {c <= 4, c >= 3 && c <= 6, c == 6, c == 7, c <= 6};
            n_checks++;
            if ({rden_o, valid_o, last_o, done_o, busy_o} !== exp_v) begin
                n_fail++; $display("FAIL basic_cycle%0d rden/valid/last/done/busy: got %b expected %b",
                                   c, {rden_o, valid_o, last_o, done_o, busy_o}, exp_v);
            end
            if (c <= 4) begin
                n_checks++;
                if (rdaddr_o !== ADDR_W'(c - 1)) begin
                    n_fail++; $display("FAIL basic_addr%0d: got %0d expected %0d", c, rdaddr_o, c - 1);
                end
            end
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (data_o !== ram[c - 3]) begin
                    n_fail++; $display("FAIL basic_data%0d: got %0h expected %0h", c, data_o, ram[c - 3]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        bit to;
        rand_ready = 1'b0;
        run_burst(142, 4, -1, to);
        n_checks++;
        if (to || rd_addrs.size() != 4 || got_data.size() != 4) begin
            n_fail++; $display("FAIL wrap_count: got to=%0d reads=%0d words=%0d expected 0 4 4", to, rd_addrs.size(), got_data.size());
        end
        for (int i = 0; i < rd_addrs.size() && i < 4; i++) begin
            n_checks++;
            if (rd_addrs[i] != (142 + i) % DEPTH) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, rd_addrs[i], (142 + i) % DEPTH);
            end
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            n_checks++;
            if (got_data[i] !== ram[(142 + i) % DEPTH] || got_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL wrap_word%0d: got %0h/%0d expected %0h/%0d", i, got_data[i], got_last[i], ram[(142 + i) % DEPTH], i == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int base;
        rand_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            base = $urandom_range(0, DEPTH - 1);
            run_burst(base, 8, -1, to);
            n_checks++;
            if (to || got_data.size() != 8 || rd_addrs.size() != 8 || dones != 1) begin
                n_fail++; $display("FAIL bp_count%0d: got to=%0d words=%0d reads=%0d dones=%0d expected 0 8 8 1", k, to, got_data.size(), rd_addrs.size(), dones);
            end
            n_checks++;
            if (viol != 0 || stab != 0) begin
                n_fail++; $display("FAIL bp_protocol%0d: got issue_viol=%0d unstable=%0d expected 0 0", k, viol, stab);
            end
            for (int i = 0; i < got_data.size() && i < 8; i++) begin
                n_checks++;
                if (got_data[i] !== ram[(base + i) % DEPTH] || got_last[i] !== (i == 7)) begin
                    n_fail++; $display("FAIL bp_word%0d_%0d: got %0h/%0d expected %0h/%0d", k, i, got_data[i], got_last[i], ram[(base + i) % DEPTH], i == 7);
                end
            end
        end
    endtask

    task automatic test_len_edges();
        bit to;
        int base;
        rand_ready = 1'b0;
        clear_mon();
        kick(7, 0);
        @(negedge clk);
        n_checks++;
        if ({done_o, busy_o, rden_o} !== 3'b100) begin
            n_fail++; $display("FAIL len0_cycle1 done/busy/rden: got %b expected 100", {done_o, busy_o, rden_o});
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (dones != 1 || rd_addrs.size() != 0 || busy_seen || got_data.size() != 0) begin
            n_fail++; $display("FAIL len0_quiet: got dones=%0d reads=%0d busy=%0d words=%0d expected 1 0 0 0", dones, rd_addrs.size(), busy_seen, got_data.size());
        end
        rand_ready = 1'b1;
        base = $urandom_range(0, DEPTH - 1);
        run_burst(base, 200, -1, to);
        n_checks++;
        if (to || rd_addrs.size() != DEPTH || got_data.size() != DEPTH || viol != 0) begin
            n_fail++; $display("FAIL len200_count: got to=%0d reads=%0d words=%0d viol=%0d expected 0 %0d %0d 0", to, rd_addrs.size(), got_data.size(), viol, DEPTH, DEPTH);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            n_checks++;
            if (got_data[i] !== ram[(base + i) % DEPTH] || got_last[i] !== (i == DEPTH - 1)) begin
                n_fail++; $display("FAIL len200_word%0d: got %0h/%0d expected %0h/%0d", i, got_data[i], got_last[i], ram[(base + i) % DEPTH], i == DEPTH - 1);
            end
        end
    endtask

    task automatic test_restart_ignored();
        bit to;
        rand_ready = 1'b1;
        run_burst(10, 12, 3, to);
        n_checks++;
        if (to || got_data.size() != 12 || rd_addrs.size() != 12 || dones != 1) begin
            n_fail++; $display("FAIL restart_count: got to=%0d words=%0d reads=%0d dones=%0d expected 0 12 12 1", to, got_data.size(), rd_addrs.size(), dones);
        end
        for (int i = 0; i < got_data.size() && i < 12; i++) begin
            n_checks++;
            if (got_data[i] !== ram[10 + i] || got_last[i] !== (i == 11)) begin
                n_fail++; $display("FAIL restart_word%0d: got %0h/%0d expected %0h/%0d", i, got_data[i], got_last[i], ram[10 + i], i == 11);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int base;
        rand_ready = 1'b0;
        clear_mon();
        kick($urandom_range(0, DEPTH - 1), 16);
        repeat (3) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, rden_o, valid_o, last_o} !== 5'b0 || rdaddr_o !== '0 || data_o !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got ctrl=%b addr=%0h data=%0h expected 0 0 0",
                               {busy_o, done_o, rden_o, valid_o, last_o}, rdaddr_o, data_o);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (dones != 0) begin
            n_fail++; $display("FAIL midrst_nodone: got %0d done pulses expected 0", dones);
        end
        rand_ready = 1'b1;
        base = $urandom_range(0, DEPTH - 1);
        run_burst(base, 10, -1, to);
        n_checks++;
        if (to || got_data.size() != 10 || dones != 1 || viol != 0 || stab != 0) begin
            n_fail++; $display("FAIL midrst_after: got to=%0d words=%0d dones=%0d viol=%0d unstable=%0d expected 0 10 1 0 0", to, got_data.size(), dones, viol, stab);
        end
        for (int i = 0; i < got_data.size() && i < 10; i++) begin
            n_checks++;
            if (got_data[i] !== ram[(base + i) % DEPTH] || got_last[i] !== (i == 9)) begin
                n_fail++; $display("FAIL midrst_word%0d: got %0h/%0d expected %0h/%0d", i, got_data[i], got_last[i], ram[(base + i) % DEPTH], i == 9);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_edges();
        test_restart_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
